// File: rtl/mmio_bridge_if.sv
// CPU memory-port bundle between the CPU, the bridge and data memory.
interface mmio_bridge_if;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [31:0] cpu_rdata;
    logic [31:0] mem_rdata;
    logic        mem_we;

    // CPU/environment side: issues accesses, supplies memory read data.
    modport master (
        output cpu_adr, cpu_wdata, cpu_we, mem_rdata,
        input  cpu_rdata, mem_we
    );

    // Bridge side: decodes accesses, returns read data, gates memory writes.
    modport slave (
        input  cpu_adr, cpu_wdata, cpu_we, mem_rdata,
        output cpu_rdata, mem_we
    );
endinterface

// File: rtl/mmio_bridge.sv
// Address decoder between the CPU memory port and data memory, with an
// on-chip I/O page holding a GPIO block and a prescaled down-counting timer.
module mmio_bridge #(
    parameter logic [31:0] IO_BASE   = 32'hFFFF_FF00,
    parameter int unsigned PRESC_DIV = 4,
    parameter int unsigned GPIO_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    mmio_bridge_if.slave      bus,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} tmr_state_t;

    localparam logic [15:0] PRESC_MAX = 16'(PRESC_DIV - 1);

    localparam logic [5:0] OFF_GPIO_OUT = 6'd0;
    localparam logic [5:0] OFF_GPIO_IN  = 6'd1;
    localparam logic [5:0] OFF_CTRL     = 6'd2;
    localparam logic [5:0] OFF_LOAD     = 6'd3;
    localparam logic [5:0] OFF_COUNT    = 6'd4;
    localparam logic [5:0] OFF_STAT     = 6'd5;

    tmr_state_t        state_q, state_d;
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] sync1_q, sync1_d;
    logic [GPIO_W-1:0] sync2_q, sync2_d;
    logic              reload_q, reload_d;
    logic              ie_q, ie_d;
    logic              exp_q, exp_d;
    logic [31:0]       load_q, load_d;
    logic [31:0]       count_q, count_d;
    logic [15:0]       presc_q, presc_d;

    logic              io_sel;
    logic              io_we;
    logic [5:0]        off;
    logic              ctrl_wr;
    logic              tick;
    logic              expiry;
    logic [31:0]       io_rd;
    logic              unused_adr_bits;

    // Byte-lane bits are irrelevant: every register is word-wide.
    assign unused_adr_bits = ^bus.cpu_adr[1:0];

    // Address decode and timer event detection.
    always_comb begin
        io_sel  = (bus.cpu_adr[31:8] == IO_BASE[31:8]);
        off     = bus.cpu_adr[7:2];
        io_we   = bus.cpu_we & io_sel;
        ctrl_wr = io_we && (off == OFF_CTRL);
        tick    = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
        expiry  = tick && (count_q == 32'd0);
    end

    // State and datapath registers; everything returns to reset values at once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            reload_q   <= 1'b0;
            ie_q       <= 1'b0;
            exp_q      <= 1'b0;
            load_q     <= '0;
            count_q    <= '0;
            presc_q    <= '0;
        end else begin
            state_q    <= state_d;
            gpio_out_q <= gpio_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            reload_q   <= reload_d;
            ie_q       <= ie_d;
            exp_q      <= exp_d;
            load_q     <= load_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
        end
    end

    // Timer next state: a CPU CTRL write beats a same-cycle one-shot expiry.
    always_comb begin
        state_d = state_q;
        if (ctrl_wr) begin
            state_d = bus.cpu_wdata[0] ? ST_RUN : ST_IDLE;
        end else if (expiry && !reload_q) begin
            state_d = ST_IDLE;
        end
    end

    // Register next values: timer countdown, EXP set/clear and CPU writes.
    always_comb begin
        gpio_out_d = gpio_out_q;
        sync1_d    = gpio_in;
        sync2_d    = sync1_q;
        reload_d   = reload_q;
        ie_d       = ie_q;
        load_d     = load_q;
        count_d    = count_q;
        exp_d      = exp_q;

        // Prescaler runs only while staying in RUN, so entering RUN starts at 0.
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
        end else begin
            presc_d = 16'd0;
        end

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (reload_q) begin
                count_d = load_q;
            end
        end

        // Setting EXP has priority over a simultaneous write-one-to-clear.
        if (expiry) begin
            exp_d = 1'b1;
        end else if (io_we && (off == OFF_STAT) && bus.cpu_wdata[0]) begin
            exp_d = 1'b0;
        end

        if (io_we) begin
            case (off)
                OFF_GPIO_OUT: gpio_out_d = bus.cpu_wdata[GPIO_W-1:0];
                OFF_CTRL: begin
                    reload_d = bus.cpu_wdata[1];
                    ie_d     = bus.cpu_wdata[2];
                end
                // A LOAD write also restarts the count, overriding any tick.
                OFF_LOAD: begin
                    load_d  = bus.cpu_wdata;
                    count_d = bus.cpu_wdata;
                end
                default: ;
            endcase
        end
    end

    // Outputs: zero-latency read mux, memory write gating, registered-only irq.
    always_comb begin
        io_rd = '0;
        case (off)
            OFF_GPIO_OUT: io_rd[GPIO_W-1:0] = gpio_out_q;
            OFF_GPIO_IN:  io_rd[GPIO_W-1:0] = sync2_q;
            OFF_CTRL:     io_rd[2:0]        = {ie_q, reload_q, (state_q == ST_RUN)};
            OFF_LOAD:     io_rd             = load_q;
            OFF_COUNT:    io_rd             = count_q;
            OFF_STAT:     io_rd[0]          = exp_q;
            default:      io_rd             = '0;
        endcase
        bus.cpu_rdata = io_sel ? io_rd : bus.mem_rdata;
        bus.mem_we    = bus.cpu_we & ~io_sel;
        gpio_out      = gpio_out_q;
        timer_irq     = exp_q & ie_q;
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: directed scenarios plus randomized traffic compared
// against a cycle-level behavioural model of the I/O page.
module tb_mmio_bridge;

    localparam int PRESC_DIV = 4;
    localparam int GPIO_W    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [GPIO_W-1:0] gpio_in = '0;
    logic [GPIO_W-1:0] gpio_out;
    logic              timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_bridge_if bus();

    mmio_bridge #(
        .IO_BASE  (32'hFFFF_FF00),
        .PRESC_DIV(PRESC_DIV),
        .GPIO_W   (GPIO_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [15:0] m_gpio_out;
    logic [15:0] m_s1, m_s2;
    bit          m_run, m_reload, m_ie, m_exp;
    logic [31:0] m_load, m_count;
    int          m_phase;

    function automatic logic [31:0] model_read(input logic [31:0] adr, input logic [31:0] mem);
        logic [31:0] r;
        r = 32'd0;
        if (adr[31:8] != 24'hFFFFFF) return mem;
        case (adr[7:2])
            6'd0: r = {16'd0, m_gpio_out};
            6'd1: r = {16'd0, m_s2};
            6'd2: r = {29'd0, m_ie, m_reload, m_run};
            6'd3: r = m_load;
            6'd4: r = m_count;
            6'd5: r = {31'd0, m_exp};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Apply one clock edge worth of rules to the model using the current inputs.
    task automatic model_edge();
        bit io, wr, tk, ex, nrun;
        logic [5:0]  off;
        logic [31:0] wd;
        io  = (bus.cpu_adr[31:8] == 24'hFFFFFF);
        wr  = bus.cpu_we && io;
        off = bus.cpu_adr[7:2];
        wd  = bus.cpu_wdata;
        if (!rst) begin
            m_gpio_out = '0; m_s1 = '0; m_s2 = '0;
            m_run = 0; m_reload = 0; m_ie = 0; m_exp = 0;
            m_load = '0; m_count = '0; m_phase = 0;
            return;
        end
        m_s2 = m_s1;
        m_s1 = gpio_in;
        tk   = m_run && (m_phase == PRESC_DIV - 1);
        ex   = tk && (m_count == 0);
        nrun = m_run;
        if (tk) begin
            if (m_count != 0) m_count = m_count - 1;
            else begin
                m_exp = 1;
                if (m_reload) m_count = m_load;
                else nrun = 0;
            end
        end
        if (m_run) m_phase = tk ? 0 : m_phase + 1;
        if (wr) begin
            case (off)
                6'd0: m_gpio_out = wd[15:0];
                6'd2: begin
                    m_reload = wd[1];
                    m_ie     = wd[2];
                    if (wd[0] && !m_run) m_phase = 0;
                    nrun = wd[0];
                end
                6'd3: begin m_load = wd; m_count = wd; end
                6'd5: if (wd[0] && !ex) m_exp = 0;
                default: ;
            endcase
        end
        m_run = nrun;
        if (!m_run) m_phase = 0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic [31:0] adr, input logic [31:0] wd, input logic we);
        bus.cpu_adr   = adr;
        bus.cpu_wdata = wd;
        bus.cpu_we    = we;
        #1;
    endtask

    task automatic bus_write(input logic [31:0] adr, input logic [31:0] wd);
        set_bus(adr, wd, 1'b1);
        step();
        bus.cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] adrs [4];
        adrs = '{32'hFFFF_FF08, 32'hFFFF_FF0C, 32'hFFFF_FF10, 32'hFFFF_FF14};
        rst = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        set_bus(32'h0, 32'h0, 1'b0);
        step();
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (gpio_out !== 16'h0) begin
            n_fail++; $display("FAIL reset_gpio_out: got %h expected 0000", gpio_out);
        end
        n_checks++;
        if (timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b expected 0", timer_irq);
        end
        foreach (adrs[i]) begin
            set_bus(adrs[i], 32'h0, 1'b0);
            n_checks++;
            if (bus.cpu_rdata !== 32'h0) begin
                n_fail++; $display("FAIL reset_read %h: got %h expected 00000000", adrs[i], bus.cpu_rdata);
            end
        end
        $display("reset: done, %0d checks so far", n_checks);
    endtask

    task automatic test_decode();
        logic [31:0] memv;
        set_bus(32'h0000_0010, 32'h1234, 1'b1);
        n_checks++;
        if (bus.mem_we !== 1'b1) begin
            n_fail++; $display("FAIL decode_mem_we: got %b expected 1", bus.mem_we);
        end
        step();
        set_bus(32'hFFFF_FF00, 32'hA5, 1'b1);
        n_checks++;
        if (bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL decode_io_mem_we: got %b expected 0", bus.mem_we);
        end
        step();
        set_bus(32'hFFFF_FF00, 32'h0, 1'b0);
        n_checks++;
        if (gpio_out !== 16'h00A5) begin
            n_fail++; $display("FAIL decode_gpio_out: got %h expected 00a5", gpio_out);
        end
        n_checks++;
        if (bus.cpu_rdata !== 32'h0000_00A5) begin
            n_fail++; $display("FAIL decode_readback: got %h expected 000000a5", bus.cpu_rdata);
        end
        memv = $urandom;
        bus.mem_rdata = memv;
        set_bus(32'h0000_0010, 32'h0, 1'b0);
        n_checks++;
        if (bus.cpu_rdata !== memv) begin
            n_fail++; $display("FAIL decode_mem_read: got %h expected %h", bus.cpu_rdata, memv);
        end
        $display("decode: store/load routing checked");
    endtask

    task automatic test_gpio_in();
        logic [31:0] exp_v [3];
        exp_v = '{32'h0, 32'h0, 32'h0000_8001};
        gpio_in = 16'h8001;
        set_bus(32'hFFFF_FF04, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus.cpu_rdata !== exp_v[k]) begin
                n_fail++; $display("FAIL gpio_in_sync cycle %0d: got %h expected %h", k, bus.cpu_rdata, exp_v[k]);
            end
            if (k < 2) step();
        end
        $display("gpio_in: 2-cycle synchronizer latency checked");
    endtask

    task automatic test_oneshot();
        bus_write(32'hFFFF_FF0C, 32'd3);
        bus_write(32'hFFFF_FF08, 32'h5);
        set_bus(32'hFFFF_FF10, 32'h0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step();
            n_checks++;
            if (timer_irq !== (k == 16)) begin
                n_fail++; $display("FAIL oneshot_irq cycle %0d: got %b expected %b", k, timer_irq, (k == 16));
            end
        end
        n_checks++;
        if (bus.cpu_rdata !== 32'h0) begin
            n_fail++; $display("FAIL oneshot_count: got %h expected 00000000", bus.cpu_rdata);
        end
        set_bus(32'hFFFF_FF08, 32'h0, 1'b0);
        n_checks++;
        if (bus.cpu_rdata !== 32'h4) begin
            n_fail++; $display("FAIL oneshot_ctrl: got %h expected 00000004", bus.cpu_rdata);
        end
        bus_write(32'hFFFF_FF14, 32'h1);
        n_checks++;
        if (timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_w1c: got %b expected 0", timer_irq);
        end
        $display("oneshot: expiry at 16 cycles and W1C checked");
    endtask

    task automatic test_autoreload();
        bit expect_irq;
        bus_write(32'hFFFF_FF0C, 32'd1);
        bus_write(32'hFFFF_FF08, 32'h7);
        for (int k = 1; k <= 24; k++) begin
            if (k == 9 || k == 24) set_bus(32'hFFFF_FF14, 32'h1, 1'b1);
            else set_bus(32'hFFFF_FF14, 32'h0, 1'b0);
            step();
            bus.cpu_we = 1'b0;
            expect_irq = (k == 8) || (k >= 16);
            n_checks++;
            if (timer_irq !== expect_irq) begin
                n_fail++; $display("FAIL autoreload_irq cycle %0d: got %b expected %b", k, timer_irq, expect_irq);
            end
        end
        bus_write(32'hFFFF_FF08, 32'h0);
        bus_write(32'hFFFF_FF14, 32'h1);
        $display("autoreload: 8-cycle period and set-beats-clear checked");
    endtask

    task automatic test_reset_midrun();
        bus_write(32'hFFFF_FF0C, 32'd2);
        bus_write(32'hFFFF_FF08, 32'h5);
        set_bus(32'hFFFF_FF10, 32'h0, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.cpu_rdata !== 32'h0) begin
            n_fail++; $display("FAIL midrun_count: got %h expected 00000000", bus.cpu_rdata);
        end
        set_bus(32'hFFFF_FF08, 32'h0, 1'b0);
        n_checks++;
        if (bus.cpu_rdata !== 32'h0) begin
            n_fail++; $display("FAIL midrun_ctrl: got %h expected 00000000", bus.cpu_rdata);
        end
        set_bus(32'hFFFF_FF14, 32'h0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step();
            n_checks++;
            if (bus.cpu_rdata !== 32'h0) begin
                n_fail++; $display("FAIL midrun_no_expiry cycle %0d: got %h expected 00000000", k, bus.cpu_rdata);
            end
        end
        $display("reset_midrun: timer cleared, no later expiry");
    endtask

    task automatic test_random();
        logic [31:0] adr, wd, expv;
        bit we, io;
        int r;
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 9);
            if (r < 8) adr = 32'hFFFF_FF00 | (r * 4) | $urandom_range(0, 3);
            else if (r == 8) adr = $urandom & 32'h7FFF_FFFF;
            else adr = 32'hFFFF_FE00 | ($urandom_range(0, 7) * 4);
            we = ($urandom_range(0, 9) < 3);
            wd = (r == 3) ? $urandom_range(0, 6) : $urandom;
            if ($urandom_range(0, 7) == 0) gpio_in = $urandom;
            bus.mem_rdata = $urandom;
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            set_bus(adr, wd, we);
            io = (adr[31:8] == 24'hFFFFFF);
            expv = model_read(adr, bus.mem_rdata);
            n_checks++;
            if (bus.cpu_rdata !== expv) begin
                n_fail++; $display("FAIL rand_rdata k=%0d adr=%h: got %h expected %h", k, adr, bus.cpu_rdata, expv);
            end
            n_checks++;
            if (bus.mem_we !== (we && !io)) begin
                n_fail++; $display("FAIL rand_mem_we k=%0d: got %b expected %b", k, bus.mem_we, (we && !io));
            end
            n_checks++;
            if (gpio_out !== m_gpio_out) begin
                n_fail++; $display("FAIL rand_gpio_out k=%0d: got %h expected %h", k, gpio_out, m_gpio_out);
            end
            n_checks++;
            if (timer_irq !== (m_exp && m_ie)) begin
                n_fail++; $display("FAIL rand_irq k=%0d: got %b expected %b", k, timer_irq, (m_exp && m_ie));
            end
            step();
        end
        rst = 1'b1;
        bus.cpu_we = 1'b0;
        $display("random: 600 cycles compared against model");
    endtask

    initial begin
        test_reset();
        test_decode();
        test_gpio_in();
        test_oneshot();
        test_autoreload();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits directly downstream of the multicycle CPU's memory port (adr, writedata, MemWrite, readdata).
- Decodes each CPU access to either data memory or an on-chip I/O page.
- The I/O page holds a GPIO block and a down-counting timer with prescaler, auto-reload and interrupt flag.
- Returns read data combinationally, so the CPU captures it into IR or the data register on the next edge unchanged.

Parameters:
- IO_BASE, 32'hFFFF_FF00, base of the 256-byte I/O page; match is on adr[31:8].
- PRESC_DIV, 4, timer tick period in clk cycles; legal range 1..65535.
- GPIO_W, 16, GPIO width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- cpu_adr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_we  in  1  CPU write strobe; one cycle per store.
- cpu_rdata  out  32  read data to CPU.
- mem_rdata  in  32  data memory read data.
- mem_we  out  1  data memory write enable.
- gpio_in  in  GPIO_W  asynchronous external inputs.
- gpio_out  out  GPIO_W  registered outputs.
- timer_irq  out  1  timer interrupt, level.

Behaviour:
- Decode: io_sel = (cpu_adr[31:8] == IO_BASE[31:8]).
  - mem_we = cpu_we & ~io_sel.
  - cpu_rdata = io_sel ? io_rd : mem_rdata, combinational, zero latency.
- I/O register map, offset adr[7:2]:
  - 0x00 GPIO_OUT, RW.
  - 0x04 GPIO_IN, RO; 2-flop synchronized, so 2-cycle input latency.
  - 0x08 TMR_CTRL, RW: bit0 EN, bit1 RELOAD, bit2 IE.
  - 0x0C TMR_LOAD, RW.
  - 0x10 TMR_COUNT, RO.
  - 0x14 TMR_STAT: bit0 EXP; write 1 to clear.
  - Unmapped offsets read 0; writes to them and to RO registers are ignored.
  - Narrow registers read zero-extended.
- All writes take effect at the clock edge where cpu_we & io_sel.
- Reset (rst==0 at edge):
  - gpio_out=0, sync flops=0, CTRL=0, LOAD=0, COUNT=0, prescaler=0, EXP=0.
  - State=IDLE; timer_irq=0.
- Timer FSM states: IDLE, RUN.
  - IDLE to RUN: CTRL write with EN=1.
  - RUN to IDLE: CTRL write with EN=0, or a one-shot expiry.
  - EN reads 1 exactly when state==RUN.
- Prescaler: counts 0..PRESC_DIV-1 while in RUN.
  - tick asserts in the cycle the prescaler equals PRESC_DIV-1; the prescaler then wraps to 0.
  - The prescaler is cleared on entry to RUN and in IDLE.
- Each tick in RUN:
  - If COUNT != 0: COUNT decrements by 1.
  - If COUNT == 0 (expiry): EXP set. If RELOAD=1, COUNT<=LOAD and stay in RUN. If RELOAD=0, COUNT stays 0, go to IDLE, EN clears.
- First expiry after enabling with COUNT=N occurs (N+1)*PRESC_DIV cycles after the enabling write edge.
- A LOAD write also sets COUNT<=wdata in the same edge.
  - This overrides a same-cycle tick decrement or reload.
  - It does not clear the prescaler.
- Simultaneous events:
  - Expiry and a W1C of EXP in the same cycle: set wins, EXP=1.
  - A CTRL write and a one-shot expiry in the same cycle: the CPU-written CTRL value wins.
- timer_irq = EXP & IE, driven from registers with no combinational path from inputs.
- Reset asserted mid-count returns everything to reset values at that edge; no pending tick survives.
- Reads have no side effects, including reads of STAT.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> gpio_out=0, timer_irq=0; reads at 0xFFFFFF08/0C/10/14 return 0.
- Decode: store 0x1234 to 0x00000010 -> mem_we=1. Store 0xA5 to 0xFFFFFF00 -> mem_we=0, gpio_out=0x00A5, readback 0x000000A5. Read 0x00000010 -> cpu_rdata=mem_rdata.
- GPIO_IN sync: set gpio_in=0x8001 -> reads at 0xFFFFFF04 return old value for 2 cycles, then 0x00008001.
- One-shot: PRESC_DIV=4, LOAD=3, CTRL=0x5 -> EXP and timer_irq rise 16 cycles after the CTRL write. COUNT then reads 0 and CTRL reads 0x4. Writing 1 to STAT drops timer_irq the next cycle.
- Auto-reload: LOAD=1, CTRL=0x7 -> EXP set every 8 cycles. Issue a W1C in an expiry cycle -> EXP remains 1.
- Reset mid-run: while COUNT=2 in RUN, pull rst low for 1 cycle -> COUNT=0, CTRL=0, no expiry afterwards.
